// File: rtl/ifmap_skew_feeder_if.sv
// Handshake and data bundle between a job controller and the ifmap skew feeder.
// The master side starts jobs and supplies vectors; the slave side drives the skewed west edge.
interface ifmap_skew_feeder_if #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned DW   = 16
);
  logic                 start;
  logic [7:0]           num_vec;
  logic                 in_valid;
  logic [ROWS*DW-1:0]   in_data;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   ifmap_west_out;
  logic [ROWS-1:0]      row_valid;
  logic                 busy;
  logic                 done;

  modport master (
    output start, num_vec, in_valid, in_data,
    input  in_ready, ifmap_west_out, row_valid, busy, done
  );

  modport slave (
    input  start, num_vec, in_valid, in_data,
    output in_ready, ifmap_west_out, row_valid, busy, done
  );
endinterface

// File: rtl/ifmap_skew_feeder.sv
// Accepts num_vec input vectors and feeds them onto a systolic array's west edge,
// delaying row r by r extra cycles, then drains the array before pulsing done.
module ifmap_skew_feeder #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 6,
  parameter int unsigned DW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  ifmap_skew_feeder_if.slave    bus
);

  localparam int unsigned DrainLen = ROWS + COLS - 1;
  localparam int unsigned DrainW   = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

  state_e            state_q;
  logic [7:0]        num_q;
  logic [7:0]        cnt_q;
  logic [DrainW-1:0] drain_q;
  logic              accept;

  assign accept = bus.in_valid && (state_q == StStream);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      num_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            num_q   <= bus.num_vec;
            cnt_q   <= '0;
            state_q <= (bus.num_vec != 8'd0) ? StStream : StDone;
          end
        end
        StStream: begin
          if (accept) begin
            // 9-bit compare so a 255-vector job never wraps the count
            if (({1'b0, cnt_q} + 9'd1) == {1'b0, num_q}) begin
              drain_q <= DrainW'(DrainLen);
              state_q <= StDrain;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        StDrain: begin
          drain_q <= drain_q - DrainW'(1);
          if (drain_q == DrainW'(1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready = (state_q == StStream);
  assign bus.busy     = (state_q == StStream) || (state_q == StDrain);
  assign bus.done     = (state_q == StDone);

  // Row r has r+1 stages so the last stage lands r cycles after row 0; chains never stall.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DW-1:0] d_q [r+1];
    logic          v_q [r+1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k <= r; k++) begin
          d_q[k] <= '0;
          v_q[k] <= 1'b0;
        end
      end else begin
        d_q[0] <= accept ? bus.in_data[r*DW +: DW] : '0;
        v_q[0] <= accept;
        for (int k = 1; k <= r; k++) begin
          d_q[k] <= d_q[k-1];
          v_q[k] <= v_q[k-1];
        end
      end
    end

    assign bus.ifmap_west_out[r*DW +: DW] = d_q[r];
    assign bus.row_valid[r]               = v_q[r];
  end

endmodule

// File: tb/tb_ifmap_skew_feeder.sv
// Bench for ifmap_skew_feeder: a job-level model pushes expected row entries into
// per-row queues at each edge; the DUT's west edge is popped and compared every cycle.
module tb_ifmap_skew_feeder;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 6;
  localparam int unsigned DW   = 16;
  localparam int unsigned DrainLen = ROWS + COLS - 1;

  typedef enum {MIdle, MStream, MDrain, MDone} mstate_t;

  logic clk = 1'b0;
  logic rst;

  ifmap_skew_feeder_if #(.ROWS(ROWS), .DW(DW)) bus ();

  ifmap_skew_feeder #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  mstate_t     m_state;
  int          m_num, m_cnt, m_drain;
  logic [DW:0] exp_q [ROWS][$];
  logic        last_acc;
  int          obs_acc, obs_busy, obs_done;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [ROWS*DW-1:0] vec(input int k);
    logic [ROWS*DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = 16'((k + 1) * 4096 + r);
    return v;
  endfunction

  task automatic reset_model();
    m_state = MIdle;
    m_num = 0; m_cnt = 0; m_drain = 0;
    for (int r = 0; r < ROWS; r++) begin
      exp_q[r].delete();
      for (int k = 0; k < r; k++) exp_q[r].push_back('0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_west"},  bus.ifmap_west_out, '0);
    check_eq({tag, "_valid"}, bus.row_valid, '0);
    check_eq({tag, "_ready"}, bus.in_ready, 1'b0);
    check_eq({tag, "_busy"},  bus.busy, 1'b0);
    check_eq({tag, "_done"},  bus.done, 1'b0);
  endtask

  // One clock: sample inputs at the edge, advance the model, compare 1 time unit later.
  task automatic cycle();
    logic               acc;
    logic [DW:0]        e;
    logic [ROWS*DW-1:0] ed;
    logic [ROWS-1:0]    ev;
    obs_acc += (bus.in_ready && bus.in_valid) ? 1 : 0;
    @(posedge clk);
    acc = bus.in_valid && (m_state == MStream);
    case (m_state)
      MIdle: if (bus.start) begin
        m_num = int'(bus.num_vec);
        m_cnt = 0;
        m_state = (m_num != 0) ? MStream : MDone;
      end
      MStream: if (acc) begin
        m_cnt++;
        if (m_cnt == m_num) begin
          m_drain = DrainLen;
          m_state = MDrain;
        end
      end
      MDrain: begin
        m_drain--;
        if (m_drain == 0) m_state = MDone;
      end
      MDone: m_state = MIdle;
      default: m_state = MIdle;
    endcase
    for (int r = 0; r < ROWS; r++) begin
      exp_q[r].push_back({acc, acc ? bus.in_data[r*DW +: DW] : 16'h0});
      e = exp_q[r].pop_front();
      ev[r] = e[DW];
      ed[r*DW +: DW] = e[DW-1:0];
    end
    last_acc = acc;
    #1;
    check_eq("row_valid", bus.row_valid, ev);
    check_eq("west_out", bus.ifmap_west_out, ed);
    check_eq("in_ready", bus.in_ready, m_state == MStream);
    check_eq("busy", bus.busy, (m_state == MStream) || (m_state == MDrain));
    check_eq("done", bus.done, m_state == MDone);
    obs_busy += bus.busy ? 1 : 0;
    obs_done += bus.done ? 1 : 0;
  endtask

  // gap: present vectors on alternate cycles; poke: re-assert start mid-stream.
  task automatic run_job(input int n, input bit gap, input bit poke);
    int k, it, exp_busy;
    obs_acc = 0; obs_busy = 0; obs_done = 0;
    bus.start = 1'b1; bus.num_vec = 8'(n); bus.in_valid = 1'b0; bus.in_data = '0;
    cycle();
    bus.start = 1'b0;
    k = 0; it = 0;
    while (m_state != MIdle && it < 2000) begin
      bus.in_valid = gap ? (it % 2 == 0) : 1'b1;
      bus.in_data  = vec(k);
      bus.start    = poke && (it == 2);
      if (poke && it == 2) bus.num_vec = 8'd9;
      cycle();
      if (last_acc) k++;
      it++;
    end
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    exp_busy = (n == 0) ? 0 : ((gap ? 2 * n - 1 : n) + DrainLen);
    check_eq("job_ended", 64'(it < 2000), 64'd1);
    check_eq("accepts", 64'(obs_acc), 64'(n));
    check_eq("done_pulses", 64'(obs_done), 64'd1);
    check_eq("busy_cycles", 64'(obs_busy), 64'(exp_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.num_vec = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    reset_model();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) cycle();

    run_job(3, 1'b0, 1'b0);    // back-to-back A,B,C
    run_job(2, 1'b1, 1'b0);    // bubble between A and B
    run_job(0, 1'b0, 1'b0);    // zero-length job
    run_job(5, 1'b0, 1'b1);    // start ignored mid-stream

    // Asynchronous reset while the chains hold data
    bus.start = 1'b1; bus.num_vec = 8'd4; bus.in_valid = 1'b0;
    cycle();
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = vec(0);
    cycle();
    bus.in_data = vec(1);
    cycle();
    check_eq("pre_rst_row0_valid", bus.row_valid[0], 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("held_rst");
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_data = '0;
    rst = 1'b1;
    reset_model();
    cycle();
    run_job(3, 1'b0, 1'b0);    // clean job after reset

    run_job(255, 1'b0, 1'b0);  // maximum length
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
